// File: rtl/rom_core_if.sv
// Dual read-port bus for the image-plane ROM: two independent address/data pairs.
interface rom_core_if;
    logic [6:0]  addra;
    logic [63:0] douta;
    logic [6:0]  addrb;
    logic [63:0] doutb;

    modport master (
        output addra,
        output addrb,
        input  douta,
        input  doutb
    );

    modport slave (
        input  addra,
        input  addrb,
        output douta,
        output doutb
    );
endinterface

// File: rtl/rom_core.sv
// Read-only bit-plane image ROM, 128 x 64, two registered read ports with 2-edge latency.
// Word addr = plane*16 + row; bit 63-c holds bit `plane` of the intensity of pixel (row, c).
module rom_core #(
    parameter int COLOR = 0
) (
    input  logic       clk,
    input  logic       rst,
    rom_core_if.slave  bus
);

    logic [6:0]  addra_q, addra_d;
    logic [6:0]  addrb_q, addrb_d;
    logic        valida_q, valida_d;
    logic        validb_q, validb_d;
    logic [63:0] douta_q, douta_d;
    logic [63:0] doutb_q, doutb_d;

    // Contents are evaluated from the intensity rule; COLOR values above 2 fall back to red.
    function automatic logic [63:0] rom_word(input logic [6:0] addr);
        logic [63:0] w;
        logic [7:0]  inten;
        logic [2:0]  plane;
        logic [3:0]  row;
        w     = '0;
        plane = addr[6:4];
        row   = addr[3:0];
        for (int c = 0; c < 64; c++) begin
            case (COLOR)
                1:       inten = 8'(17 * int'(row));
                2:       inten = 8'(255 - 4 * c);
                default: inten = 8'(4 * c);
            endcase
            w[63 - c] = inten[plane];
        end
        return w;
    endfunction

    // The valid flags keep the output at zero until an address captured after reset is read.
    always_comb begin
        addra_d  = bus.addra;
        addrb_d  = bus.addrb;
        valida_d = 1'b1;
        validb_d = 1'b1;
        douta_d  = valida_q ? rom_word(addra_q) : 64'h0;
        doutb_d  = validb_q ? rom_word(addrb_q) : 64'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addra_q  <= '0;
            addrb_q  <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
            douta_q  <= 64'h0;
            doutb_q  <= 64'h0;
        end else begin
            addra_q  <= addra_d;
            addrb_q  <= addrb_d;
            valida_q <= valida_d;
            validb_q <= validb_d;
            douta_q  <= douta_d;
            doutb_q  <= doutb_d;
        end
    end

    assign bus.douta = douta_q;
    assign bus.doutb = doutb_q;

endmodule

// File: tb/tb_rom_core.sv
// Bench for rom_core: three color instances, directed vectors plus random dual-port reads.
module tb_rom_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rom_core_if bus_r ();
    rom_core_if bus_g ();
    rom_core_if bus_b ();

    rom_core #(.COLOR(0)) dut_r (.clk(clk), .rst(rst), .bus(bus_r.slave));
    rom_core #(.COLOR(1)) dut_g (.clk(clk), .rst(rst), .bus(bus_g.slave));
    rom_core #(.COLOR(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Reference: intensity per pixel, then pick bit `plane` by shift/mod.
    function automatic logic [63:0] model_word(input int color, input int addr);
        logic [63:0] w;
        int plane, row, inten;
        w     = '0;
        plane = addr / 16;
        row   = addr % 16;
        for (int c = 0; c < 64; c++) begin
            if (color == 1)      inten = 17 * row;
            else if (color == 2) inten = 255 - 4 * c;
            else                 inten = 4 * c;
            w[63 - c] = ((inten >> plane) % 2) == 1;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [6:0] a, input logic [6:0] b);
        bus_r.addra = a; bus_g.addra = a; bus_b.addra = a;
        bus_r.addrb = b; bus_g.addrb = b; bus_b.addrb = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_all(7'h25, 7'h03);
        tick();
        tick();
        total++;
        if (bus_r.douta !== 64'h0 || bus_r.doutb !== 64'h0) begin
            bad++;
            $display("FAIL reset_red got a=%h b=%h exp 0", bus_r.douta, bus_r.doutb);
        end
        total++;
        if (bus_b.douta !== 64'h0 || bus_g.doutb !== 64'h0) begin
            bad++;
            $display("FAIL reset_blue_green got a=%h b=%h exp 0", bus_b.douta, bus_g.doutb);
        end
        // Blue word 0 is all ones, so a zero here proves the post-reset gap is honoured.
        set_all(7'h00, 7'h00);
        rst = 1'b0;
        tick();
        total++;
        if (bus_b.douta !== 64'h0) begin
            bad++;
            $display("FAIL reset_release_gap got %h exp 0", bus_b.douta);
        end
        tick();
        total++;
        if (bus_b.douta !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL reset_release_first got %h exp all ones", bus_b.douta);
        end
    endtask

    task automatic test_red();
        set_all(7'h20, 7'h12);
        tick();
        tick();
        total++;
        if (bus_r.douta !== 64'h5555_5555_5555_5555) begin
            bad++;
            $display("FAIL red_20 got %h exp 5555555555555555", bus_r.douta);
        end
        total++;
        if (bus_r.doutb !== 64'h0) begin
            bad++;
            $display("FAIL red_12 got %h exp 0", bus_r.doutb);
        end
    endtask

    task automatic test_green();
        logic [6:0]  addrs [3] = '{7'h03, 7'h77, 7'h7F};
        logic [63:0] exps  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            set_all(7'h00, addrs[i]);
            tick();
            tick();
            total++;
            if (bus_g.doutb !== exps[i]) begin
                bad++;
                $display("FAIL green_%h got %h exp %h", addrs[i], bus_g.doutb, exps[i]);
            end
        end
    endtask

    task automatic test_blue();
        set_all(7'h00, 7'h25);
        tick();
        tick();
        total++;
        if (bus_b.douta !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL blue_00 got %h exp all ones", bus_b.douta);
        end
        total++;
        if (bus_b.doutb !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            bad++;
            $display("FAIL blue_25 got %h exp aaaaaaaaaaaaaaaa", bus_b.doutb);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exps [3] = '{64'h5555_5555_5555_5555, 64'h0, 64'h5555_5555_5555_5555};
        set_all(7'h20, 7'h00); tick();
        set_all(7'h12, 7'h00); tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_all(7'h20, 7'h00);
            total++;
            if (bus_r.douta !== exps[i]) begin
                bad++;
                $display("FAIL b2b_%0d got %h exp %h", i, bus_r.douta, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        set_all(7'h20, 7'h20);
        tick();
        tick();
        total++;
        if (bus_r.douta !== 64'h5555_5555_5555_5555) begin
            bad++;
            $display("FAIL mid_before got %h exp 5555555555555555", bus_r.douta);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus_r.douta !== 64'h0) begin
            bad++;
            $display("FAIL mid_cleared got %h exp 0", bus_r.douta);
        end
        tick();
        total++;
        if (bus_r.douta !== 64'h0) begin
            bad++;
            $display("FAIL mid_gap got %h exp 0", bus_r.douta);
        end
        tick();
        total++;
        if (bus_r.douta !== 64'h5555_5555_5555_5555) begin
            bad++;
            $display("FAIL mid_return got %h exp 5555555555555555", bus_r.douta);
        end
    endtask

    task automatic test_random_dual();
        logic [6:0]  hist [$];
        logic [6:0]  a;
        logic [63:0] oa [3];
        logic [63:0] ob [3];
        logic [63:0] exp_w;
        for (int i = 0; i < 200; i++) begin
            a = (i == 100) ? 7'h7F : (i == 101) ? 7'h00 : 7'($urandom_range(0, 127));
            set_all(a, a);
            hist.push_back(a);
            tick();
            if (hist.size() > 1) begin
                oa[0] = bus_r.douta; ob[0] = bus_r.doutb;
                oa[1] = bus_g.douta; ob[1] = bus_g.doutb;
                oa[2] = bus_b.douta; ob[2] = bus_b.doutb;
                for (int c = 0; c < 3; c++) begin
                    exp_w = model_word(c, int'(hist[0]));
                    total++;
                    if (oa[c] !== exp_w || ob[c] !== exp_w) begin
                        bad++;
                        $display("FAIL rand c%0d cyc%0d addr %h got a=%h b=%h exp %h",
                                 c, i, hist[0], oa[c], ob[c], exp_w);
                    end
                end
                void'(hist.pop_front());
            end
        end
    endtask

    initial begin
        set_all(7'h00, 7'h00);
        test_reset();
        test_red();
        test_green();
        test_blue();
        test_back_to_back();
        test_reset_midstream();
        test_random_dual();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_core.md
ROM_CORE -- requirements
Module: rom_core

Interface
REQ-001 SHALL have parameter COLOR, default 0, selects image plane contents: 0 = red, 1 = green, 2 = blue; values 3 and above behave as 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; both read ports sample on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port addra, input, 7 bits: port A read address.
REQ-005 SHALL have port douta, output, 64 bits: port A read data, registered.
REQ-006 SHALL have port addrb, input, 7 bits: port B read address.
REQ-007 SHALL have port doutb, output, 64 bits: port B read data, registered.
REQ-008 SHALL be read-only, with no write port; the system instantiates it three times, once per COLOR, sharing one clk.

Function
REQ-009 SHALL hold 128 words of 64 bits; address = plane*16 + row, where plane = addr[6:4] (0-7) and row = addr[3:0] (0-15).
REQ-010 SHALL store one bit per pixel per word: word[63-c] = bit `plane` of intensity I(row, c), for column c = 0..63 (bit 63 = column 0).
REQ-011 SHALL use 8-bit intensity I(r,c): red = 4*c; green = 17*r; blue = 255 - 4*c (all values fit in 8 bits, no wrap).
REQ-012 SHALL derive contents either from a constant table or from combinational/initial evaluation of REQ-011; the observable data SHALL be identical either way.
REQ-013 SHALL have a read latency of exactly 2 clk rising edges per port:
- edge k: address register captures addrX;
- edge k+1: output register loads word[address register];
- doutX is valid after edge k+1 and held until the next load.
REQ-014 SHALL fully pipeline the read: a new address may be applied every cycle, giving one result per cycle.
REQ-015 SHALL keep ports A and B independent; the same address on both ports SHALL yield identical data in the same cycle.
REQ-016 SHALL cover all 128 addresses, with no out-of-range case; address 127 followed by address 0 needs no special handling.
REQ-017 SHALL have no combinational path from addrX to doutX.

Reset
REQ-018 SHALL, on a rising clk edge with rst=1, clear both address registers to 0 and both output registers to 64'h0.
REQ-019 SHALL give rst priority over an address capture in the same cycle.
REQ-020 SHALL, after rst deasserts, return data for the first captured address 2 edges later; until then doutX reads 0.
REQ-021 SHALL also apply REQ-018 when rst asserts mid-operation, discarding any in-flight read.
REQ-022 SHALL have no reset-dependent contents; the ROM array is never cleared.

Verification
REQ-023 SHALL pass: COLOR=0, addra=7'h20 (plane 2, row 0) -> douta = 64'h5555_5555_5555_5555 two edges later; addra=7'h12 -> douta = 64'h0.
REQ-024 SHALL pass: COLOR=1, addrb=7'h03 -> doutb = 64'hFFFF_FFFF_FFFF_FFFF; addrb=7'h77 (plane 7, row 7, I=119) -> 64'h0; addrb=7'h7F -> all ones.
REQ-025 SHALL pass: COLOR=2, addra=7'h00 -> all ones; addra=7'h25 -> douta = 64'hAAAA_AAAA_AAAA_AAAA.
REQ-026 SHALL pass: back-to-back addresses 0x20, 0x12, 0x20 on consecutive cycles (COLOR=0) -> douta sequence 5555..., 0, 5555... starting 2 edges after the first, one result per cycle.
REQ-027 SHALL pass: rst=1 for 1 edge while douta = 5555... -> douta = 0 after that edge; after release, the held address reappears exactly 2 edges later.
REQ-028 SHALL pass: addra = addrb = random values over 200 cycles -> douta == doutb every cycle, and both match the REQ-010/011 model delayed by 2 cycles.
